// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (IF, read-only)
// and load/store (DM, read/write) with a 3-state sequencer and round-robin tie-breaking.
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic                 if_ack,
    output logic [WORD_SIZE-1:0] if_rdata,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [ADDR_SIZE-1:0] dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic                 dm_ack,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic [ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_data_in,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_data_out,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Port select encoding: 0 = IF, 1 = DM.
    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_DM = 1'b1;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 sel_q, sel_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d;
    logic [WORD_SIZE-1:0] dm_rdata_q, dm_rdata_d;
    logic                 grant_dm;

    // On a tie the port that did not win last time is served.
    assign grant_dm = dm_req && (!if_req || (last_grant_q == SEL_IF));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    sel_d   = grant_dm ? SEL_DM : SEL_IF;
                    addr_d  = grant_dm ? dm_addr : if_addr;
                    we_d    = grant_dm ? dm_we : 1'b0;
                    wdata_d = grant_dm ? dm_wdata : '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (sel_q == SEL_DM) dm_rdata_d = mem_data_out;
                    else                 if_rdata_d = mem_data_out;
                end
                state_d = DONE;
            end
            DONE: begin
                last_grant_d = sel_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SEL_DM;
            sel_q        <= SEL_IF;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    // Strobes decode straight from state so an async reset removes them at once.
    assign mem_address = addr_q;
    assign mem_data_in = wdata_q;
    assign mem_write   = (state_q == ACCESS) && we_q && (sel_q == SEL_DM);
    assign busy        = (state_q != IDLE);
    assign if_ack      = (state_q == DONE) && (sel_q == SEL_IF);
    assign dm_ack      = (state_q == DONE) && (sel_q == SEL_DM);
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural combinational-read memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic        if_ack, dm_ack, mem_write, busy;
    logic [15:0] if_rdata, dm_rdata, mem_address, mem_data_in, mem_data_out;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_address];
    always @(posedge clk) if (mem_write) mem[mem_address] = mem_data_in;

    mem_port_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write(mem_write),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
        rst = 1'b1;
        #1;
        checks++;
        if ({if_ack, dm_ack, mem_write, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got=%b exp=0000", {if_ack, dm_ack, mem_write, busy});
        end
        checks++;
        if ({if_rdata, dm_rdata, mem_address, mem_data_in} !== 64'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {if_rdata, dm_rdata, mem_address, mem_data_in});
        end
        do_reset();
    endtask

    task automatic test_if_read();
        mem[16'h0010] = 16'h1234;
        if_req = 1; if_addr = 16'h0010;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ifrd_c0_busy got=%b exp=0", busy); end
        tick();
        checks++;
        if ({busy, if_ack, dm_ack, mem_write, mem_address} !== {4'b1000, 16'h0010}) begin
            errors++; $display("FAIL ifrd_c1 got=%b_%h exp=1000_0010", {busy, if_ack, dm_ack, mem_write}, mem_address);
        end
        tick();
        checks++;
        if ({busy, if_ack, dm_ack, if_rdata} !== {3'b110, 16'h1234}) begin
            errors++; $display("FAIL ifrd_c2 got=%b_%h exp=110_1234", {busy, if_ack, dm_ack}, if_rdata);
        end
        if_req = 0;
        tick();
        checks++;
        if ({busy, if_ack, if_rdata} !== {2'b00, 16'h1234}) begin
            errors++; $display("FAIL ifrd_c3 got=%b_%h exp=00_1234", {busy, if_ack}, if_rdata);
        end
    endtask

    task automatic test_dm_write_wrap();
        dm_req = 1; dm_we = 1; dm_addr = 16'hFFFF; dm_wdata = 16'hBEEF;
        tick();
        checks++;
        if ({mem_write, dm_ack, mem_address, mem_data_in} !== {2'b10, 16'hFFFF, 16'hBEEF}) begin
            errors++; $display("FAIL dmwr_access got=%b_%h_%h exp=10_ffff_beef", {mem_write, dm_ack}, mem_address, mem_data_in);
        end
        tick();
        checks++;
        if ({mem_write, dm_ack, if_ack, dm_rdata} !== {3'b010, 16'h0000}) begin
            errors++; $display("FAIL dmwr_done got=%b_%h exp=010_0000", {mem_write, dm_ack, if_ack}, dm_rdata);
        end
        checks++;
        if (mem[16'hFFFF] !== 16'hBEEF) begin errors++; $display("FAIL dmwr_mem got=%h exp=beef", mem[16'hFFFF]); end
        dm_we = 0; dm_wdata = 0;
        tick();
        tick();
        checks++;
        if (mem_write !== 1'b0) begin errors++; $display("FAIL dmrd_nowrite got=%b exp=0", mem_write); end
        tick();
        checks++;
        if ({dm_ack, dm_rdata} !== {1'b1, 16'hBEEF}) begin
            errors++; $display("FAIL dmrd_ffff got=%b_%h exp=1_beef", dm_ack, dm_rdata);
        end
        dm_req = 0;
        tick();
    endtask

    task automatic test_alternate();
        logic exp_if, exp_dm;
        do_reset();
        mem[16'h0020] = 16'hAAAA;
        mem[16'h0030] = 16'h5555;
        if_req = 1; if_addr = 16'h0020;
        dm_req = 1; dm_we = 0; dm_addr = 16'h0030;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_if = (k % 6 == 2);
            exp_dm = (k % 6 == 5);
            checks++;
            if ({if_ack, dm_ack} !== {exp_if, exp_dm}) begin
                errors++; $display("FAIL alt_acks cycle=%0d got=%b exp=%b", k, {if_ack, dm_ack}, {exp_if, exp_dm});
            end
        end
        checks++;
        if ({if_rdata, dm_rdata} !== {16'hAAAA, 16'h5555}) begin
            errors++; $display("FAIL alt_rdata got=%h_%h exp=aaaa_5555", if_rdata, dm_rdata);
        end
        if_req = 0; dm_req = 0;
        tick();
    endtask

    task automatic test_late_dm();
        mem[16'h0030] = 16'h6666;
        if_req = 1; if_addr = 16'h0010;
        tick();
        dm_req = 1; dm_we = 0; dm_addr = 16'h0030;
        tick();
        checks++;
        if ({if_ack, dm_ack, if_rdata} !== {2'b10, 16'h1234}) begin
            errors++; $display("FAIL late_if_done got=%b_%h exp=10_1234", {if_ack, dm_ack}, if_rdata);
        end
        if_req = 0;
        tick();
        checks++;
        if ({busy, dm_ack} !== 2'b00) begin errors++; $display("FAIL late_idle got=%b exp=00", {busy, dm_ack}); end
        tick();
        checks++;
        if ({busy, dm_ack, mem_address} !== {2'b10, 16'h0030}) begin
            errors++; $display("FAIL late_dm_access got=%b_%h exp=10_0030", {busy, dm_ack}, mem_address);
        end
        tick();
        checks++;
        if ({dm_ack, if_ack, dm_rdata} !== {2'b10, 16'h6666}) begin
            errors++; $display("FAIL late_dm_ack got=%b_%h exp=10_6666", {dm_ack, if_ack}, dm_rdata);
        end
        dm_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        mem[16'h0040] = 16'h0000;
        dm_req = 1; dm_we = 1; dm_addr = 16'h0040; dm_wdata = 16'h7777;
        tick();
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", mem_write); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_write, busy, if_ack, dm_ack, mem_address} !== {4'b0000, 16'h0000}) begin
            errors++; $display("FAIL rstmid_async got=%b_%h exp=0000_0000", {mem_write, busy, if_ack, dm_ack}, mem_address);
        end
        dm_req = 0; dm_we = 0; dm_wdata = 0;
        #2;
        rst = 1'b0;
        if_req = 1; if_addr = 16'h0010;
        dm_req = 1; dm_addr = 16'h0030;
        tick();
        checks++;
        if ({busy, mem_address} !== {1'b1, 16'h0010}) begin
            errors++; $display("FAIL rstmid_tie got=%b_%h exp=1_0010", busy, mem_address);
        end
        tick();
        checks++;
        if ({if_ack, dm_ack} !== 2'b10) begin errors++; $display("FAIL rstmid_ack got=%b exp=10", {if_ack, dm_ack}); end
        if_req = 0; dm_req = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        mem[16'h0001] = 16'h1111;
        mem[16'h0002] = 16'h2222;
        if_req = 1; if_addr = 16'h0001;
        tick();
        tick();
        checks++;
        if ({if_ack, if_rdata} !== {1'b1, 16'h1111}) begin
            errors++; $display("FAIL b2b_first got=%b_%h exp=1_1111", if_ack, if_rdata);
        end
        if_addr = 16'h0002;
        tick();
        checks++;
        if ({if_ack, busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle got=%b exp=00", {if_ack, busy}); end
        tick();
        checks++;
        if (mem_address !== 16'h0002) begin errors++; $display("FAIL b2b_addr got=%h exp=0002", mem_address); end
        tick();
        checks++;
        if ({if_ack, if_rdata} !== {1'b1, 16'h2222}) begin
            errors++; $display("FAIL b2b_second got=%b_%h exp=1_2222", if_ack, if_rdata);
        end
        if_req = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        test_reset();
        test_if_read();
        test_dm_write_wrap();
        test_alternate();
        test_late_dm();
        test_reset_mid_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported 16-bit unified memory between the MIPS16e instruction-fetch path (IF, read-only) and the load/store path (DM, read/write).
- Uses a req/ack handshake per requester, a 3-state sequencer, and round-robin tie-breaking.
- Registers and holds read data per port.
- Sits between the CPU pipeline and the memory unit; drives that unit's address, data_in and write pins, and samples its combinational data_out.

Parameters:
- WORD_SIZE, 16, data width of memory words and read/write data.
- ADDR_SIZE, 16, address width; must match the memory address width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  ADDR_SIZE  fetch address; stable while if_req is high.
- if_ack  output  1  one-cycle pulse; fetch complete, if_rdata valid.
- if_rdata  output  WORD_SIZE  last fetched word.
- dm_req  input  1  data request; held high until dm_ack.
- dm_we  input  1  1 = write, 0 = read; stable while dm_req is high.
- dm_addr  input  ADDR_SIZE  data address; stable while dm_req is high.
- dm_wdata  input  WORD_SIZE  write data; stable while dm_req is high.
- dm_ack  output  1  one-cycle pulse; data access complete.
- dm_rdata  output  WORD_SIZE  last loaded word.
- mem_address  output  ADDR_SIZE  to memory address.
- mem_data_in  output  WORD_SIZE  to memory data_in.
- mem_write  output  1  to memory write.
- mem_data_out  input  WORD_SIZE  from memory data_out (combinational read).
- busy  output  1  high in ACCESS and DONE states.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; last_grant = DM.
  - All outputs 0: if_ack, dm_ack, mem_write, busy, if_rdata, dm_rdata, mem_address, mem_data_in.
  - Reset asserted mid-access aborts it: mem_write drops immediately, no ack is issued, and any unfinished write may or may not have landed.
- States:
  - IDLE: sample requests. At the clock edge, if any request is pending: latch sel, addr, we, wdata; go to ACCESS.
  - ACCESS: mem_address = latched addr; mem_data_in = latched wdata; mem_write = latched we AND sel==DM. At the edge: capture mem_data_out into if_rdata or dm_rdata (reads only); go to DONE.
  - DONE: the selected port's ack = 1 for exactly this cycle. Requests are ignored. At the edge, go to IDLE and set last_grant = sel.
- Arbitration in IDLE:
  - Only if_req high: grant IF.
  - Only dm_req high: grant DM.
  - Both high: grant the port that is NOT last_grant. The first tie after reset goes to IF.
- Latency: request seen in IDLE cycle N, memory access in cycle N+1, ack in cycle N+2. Maximum throughput is one access per 3 cycles.
- With both ports saturating, grants strictly alternate: a port waits at most one other access (3 cycles) before its own access starts.
- Handshake: the requester sees ack at the end of the DONE cycle and may drop req or present a new request. A req still high in the following IDLE cycle is a new request.
- IF writes are impossible; mem_write is driven only for DM with dm_we = 1.
- A DM write does not change dm_rdata.
- mem_address, mem_data_in and rdata registers hold their values outside ACCESS.
- Address wrap: none internally; addresses pass through unmodified (0xFFFF is valid).
- A req dropped before its grant is simply not served. A req dropped after it is latched still completes and still acks.

Test Plan:
- Reset, then if_req=1, if_addr=0x0010 with mem[0x0010]=0x1234 -> ACCESS at cycle 1; if_ack pulses in cycle 2 with if_rdata=0x1234; busy high in cycles 1–2; dm_ack stays 0.
- dm_req=1, dm_we=1, dm_addr=0xFFFF, dm_wdata=0xBEEF -> mem_write high only in the ACCESS cycle with mem_address=0xFFFF; dm_ack next cycle; dm_rdata unchanged. A later DM read of 0xFFFF returns 0xBEEF.
- if_req and dm_req both held high continuously from reset -> grant order IF, DM, IF, DM; acks spaced 3 cycles apart, alternating.
- A DM request arriving while an IF access is in ACCESS -> DM is not granted until IDLE; dm_ack 3 cycles after if_ack; ACCESS and DONE are never interrupted.
- rst asserted during ACCESS of a DM write -> mem_write, busy and acks drop to 0 without a clock edge; after release the state is IDLE and last_grant = DM.
- Requester keeps req high through ack with a new address (0x0001, then 0x0002) -> two distinct accesses; each ack returns the matching memory word.
